// File: rtl/vc_dequeue_arbiter.sv
// Weighted round-robin dequeue of two virtual-channel FIFOs into one registered
// output slot with a valid/ready handshake toward the egress link.
module vc_dequeue_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int W0         = 3,
    parameter int W1         = 1,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  vc0_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    output logic                  vc0_pop,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    output logic                  vc1_pop,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_vc,
    output logic                  idle
);

    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

    // A zero weight still grants one word per turn.
    localparam logic [CNT_W-1:0] RELOAD0 = (W0 == 0) ? CNT_W'(1) : CNT_W'(W0);
    localparam logic [CNT_W-1:0] RELOAD1 = (W1 == 0) ? CNT_W'(1) : CNT_W'(W1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] credit, credit_nxt;
    logic             slot_free;
    logic             pop0, pop1;

    assign slot_free = !out_valid || out_ready;

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        pop0       = 1'b0;
        pop1       = 1'b0;
        case (state)
            IDLE: begin
                if (!vc0_empty) begin
                    state_nxt  = SERVE0;
                    credit_nxt = RELOAD0;
                end else if (!vc1_empty) begin
                    state_nxt  = SERVE1;
                    credit_nxt = RELOAD1;
                end
            end
            SERVE0: begin
                // Backpressure freezes the turn entirely, including its credit.
                if (!slot_free) begin
                    state_nxt = SERVE0;
                end else if (vc0_empty) begin
                    if (!vc1_empty) begin
                        state_nxt  = SERVE1;
                        credit_nxt = RELOAD1;
                    end else begin
                        state_nxt  = IDLE;
                        credit_nxt = '0;
                    end
                end else begin
                    pop0 = 1'b1;
                    if (credit > CNT_W'(1)) begin
                        credit_nxt = credit - CNT_W'(1);
                    end else if (!vc1_empty) begin
                        state_nxt  = SERVE1;
                        credit_nxt = RELOAD1;
                    end else begin
                        credit_nxt = RELOAD0;
                    end
                end
            end
            SERVE1: begin
                if (!slot_free) begin
                    state_nxt = SERVE1;
                end else if (vc1_empty) begin
                    if (!vc0_empty) begin
                        state_nxt  = SERVE0;
                        credit_nxt = RELOAD0;
                    end else begin
                        state_nxt  = IDLE;
                        credit_nxt = '0;
                    end
                end else begin
                    pop1 = 1'b1;
                    if (credit > CNT_W'(1)) begin
                        credit_nxt = credit - CNT_W'(1);
                    end else if (!vc0_empty) begin
                        state_nxt  = SERVE0;
                        credit_nxt = RELOAD0;
                    end else begin
                        credit_nxt = RELOAD1;
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                credit_nxt = '0;
            end
        endcase
    end

    // Pops are gated by reset so the FIFOs never lose a word during reset.
    assign vc0_pop = pop0 && reset_L;
    assign vc1_pop = pop1 && reset_L;
    assign idle    = (state == IDLE) && !out_valid;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state  <= IDLE;
            credit <= '0;
        end else begin
            state  <= state_nxt;
            credit <= credit_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_vc    <= 1'b0;
        end else if (pop0) begin
            out_valid <= 1'b1;
            out_data  <= vc0_data;
            out_vc    <= 1'b0;
        end else if (pop1) begin
            out_valid <= 1'b1;
            out_data  <= vc1_data;
            out_vc    <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
